// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter for the IF fetch port and MEM data port.
// Optional IF starvation guard is enabled with `define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 64,
  parameter int MAX_D_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

  state_t              state_q, state_d;
  logic                owner_d_q, owner_d_d;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;
  logic                err_q, err_d;
  logic                take_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int BURST_W = $clog2(MAX_D_BURST + 1);
  logic [BURST_W-1:0]  burst_q, burst_d;
`else
  logic                unused_max_d_burst;
  assign unused_max_d_burst = |MAX_D_BURST;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    take_d      = dm_req_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
    burst_d     = burst_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (!if_req_i) burst_d = '0;
        if (if_req_i && burst_q >= BURST_W'(MAX_D_BURST)) take_d = 1'b0;
`endif
        if (take_d) begin
          state_d     = GNT_D;
          owner_d_d   = 1'b1;
          tmo_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
          if (if_req_i) burst_d = burst_q + BURST_W'(1);
`endif
        end else if (if_req_i) begin
          state_d    = GNT_I;
          owner_d_d  = 1'b0;
          tmo_d      = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
          burst_d    = '0;
`endif
        end
      end
      GNT_I, GNT_D: begin
        tmo_d = tmo_q + CNT_W'(1);
        if (mem_ack_i || tmo_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          err_d     = !mem_ack_i;
          if (owner_d_q) begin
            dm_ack_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = mem_ack_i ? mem_rdata_i : '1;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack_i ? mem_rdata_i : '1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      burst_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_d_q   <= owner_d_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
      burst_q     <= burst_d;
`endif
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign err_o       = err_q;
  assign stall_o     = rst_i & ((if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q));

endmodule
